// File: rtl/coef_pkg.sv
// -----------------------------------------------------------------------------
// coef_pkg
//   Shared definitions for the coefficient path. The coefficient receiver and
//   the bit-plane slicer both import this package, so the coefficient width and
//   the default word length are defined in exactly one place.
//
//   COEF_W     : width of one coefficient (bit 1 = MSB, bit 0 = LSB)
//   COEF_N     : default number of coefficients packed into one bit-plane word
//   coef_t     : convenience type for a single coefficient
//   cnt_width  : width of a fill counter that must hold 0..n-1
// -----------------------------------------------------------------------------
package coef_pkg;

  localparam int COEF_W = 2;
  localparam int COEF_N = 4;

  typedef logic [COEF_W-1:0] coef_t;

  // A counter over 0..n-1 needs ceil(log2(n)) bits. The result is clamped to at
  // least 1 bit so that a degenerate word length still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : coef_pkg

// File: rtl/coef_slicer.sv
// -----------------------------------------------------------------------------
// coef_slicer
//   Collects N consecutive 2-bit coefficients and emits them as two N-bit
//   bit-planes: plane0 gathers the LSBs and plane1 gathers the MSBs. The k-th
//   accepted coefficient of a word lands in bit k of both planes.
//
//   The input side is a valid/ready stream carrying one coefficient per
//   transfer. The output side is a valid/ready stream carrying one word per
//   transfer. The block sustains one coefficient per cycle. It stalls only the
//   coefficient that would complete a word, and only while the previous word is
//   still waiting in the output register.
//
// Parameters
//   N          coefficients per bit-plane word (N >= 2)
//
// Ports
//   clk        sole clock; all state updates on the rising edge
//   reset      synchronous, active-high reset
//   coef_in    incoming coefficient, bit 1 = MSB
//   in_valid   coef_in is valid this cycle
//   in_ready   block accepts coef_in this cycle
//   plane0     LSB bit-plane of the output word
//   plane1     MSB bit-plane of the output word
//   out_valid  plane0/plane1 hold a complete word
//   out_ready  consumer takes the word this cycle
// -----------------------------------------------------------------------------
module coef_slicer
  import coef_pkg::*;
#(
  parameter int N = COEF_N
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COEF_W-1:0] coef_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N-1:0]      plane0,
  output logic [N-1:0]      plane1,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int               CNT_W    = cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Fill counter: index of the slot that the next accepted coefficient fills.
  logic [CNT_W-1:0] cnt;

  // Assembly registers for the word that is currently being filled.
  logic [N-1:0]     asm0;
  logic [N-1:0]     asm1;

  // Assembly contents after the coefficient on coef_in has been merged in.
  logic [N-1:0]     asm0_next;
  logic [N-1:0]     asm1_next;

  logic             at_last;     // the next transfer completes the word
  logic             in_xfer;     // input transfer this cycle
  logic             out_xfer;    // output transfer this cycle
  logic             word_done;   // input transfer that completes the word

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  // Only the completing coefficient has to wait for room in the output
  // register. Room exists when the register is empty, or when it is being
  // drained on this same cycle. in_ready depends only on registered state and
  // out_ready, so no combinational path runs from in_valid to in_ready.
  assign at_last   = (cnt == CNT_LAST);
  assign in_ready  = !(at_last && out_valid && !out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign word_done = in_xfer && at_last;

  // ---------------------------------------------------------------------------
  // Word assembly (combinational merge)
  // ---------------------------------------------------------------------------
  // When a new word starts (cnt == 0), the merge begins from zero. This clears
  // any bits left over from the previous word, so slots that are not yet filled
  // always read as 0 and never carry stale data.
  // NOTE: every signal driven here gets a full default on the first line, so no
  // path through the block leaves it unassigned and no latch can be inferred.
  always_comb begin
    asm0_next      = (cnt == '0) ? '0 : asm0;
    asm1_next      = (cnt == '0) ? '0 : asm1;
    asm0_next[cnt] = coef_in[0];
    asm1_next[cnt] = coef_in[1];
  end

  // ---------------------------------------------------------------------------
  // Fill counter and assembly registers
  // ---------------------------------------------------------------------------
  // A bubble (no input transfer) leaves both the counter and the assembly
  // registers untouched.
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the pre-edge values of the others, whatever the order of the
  // statements.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      asm0 <= '0;
      asm1 <= '0;
    end else if (in_xfer) begin
      asm0 <= asm0_next;
      asm1 <= asm1_next;
      cnt  <= at_last ? '0 : cnt + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  // A completed word is captured directly from the merge result. out_valid
  // therefore rises one cycle after the last coefficient is accepted.
  //
  // Priority on a given cycle:
  //   1. reset              - discards any pending word
  //   2. word completes     - load the new word; out_valid stays or becomes 1.
  //                           This case can also coincide with a drain of the
  //                           old word, because in_ready only allows the
  //                           completing transfer when the register is empty
  //                           or draining, so no word is overwritten.
  //   3. drain only         - clear out_valid
  //   4. otherwise          - hold planes and out_valid stable
  // NOTE: the planes are reset together with out_valid. They are plain
  // registers rather than a memory array, so clearing them costs nothing, and
  // the consumer never observes X on them after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      plane0    <= '0;
      plane1    <= '0;
      out_valid <= 1'b0;
    end else if (word_done) begin
      plane0    <= asm0_next;
      plane1    <= asm1_next;
      out_valid <= 1'b1;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule : coef_slicer
